// File: rtl/ddr2_line_bridge_pkg.sv
// ddr2_line_bridge_pkg: shared states, line geometry and timeout constant for the DDR2 line bridge.
package ddr2_line_bridge_pkg;
  typedef enum logic [2:0] {S_IDLE, S_MRG_RD, S_MRG_WAIT, S_WR_REQ, S_FILL_RD, S_FILL_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {P_NONE, P_WR, P_RD, P_FL} pend_e;
  localparam int LINE_WORDS = 4;
  localparam int LINE_W = 32 * LINE_WORDS;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
  function automatic logic [31:0] word_of(input logic [LINE_W-1:0] line, input logic [1:0] sel);
    return line[{sel, 5'b0} +: 32];
  endfunction
endpackage

// File: rtl/ddr2_line_buf.sv
// ddr2_line_buf: one 128-bit line with tag, valid and per-word mask; word writes and masked line merges.
module ddr2_line_buf
  import ddr2_line_bridge_pkg::*;
#(
  parameter int TAG_W = 24
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  wr_i,
  input  logic                  ld_i,
  input  logic [TAG_W-1:0]      tag_i,
  input  logic [1:0]            sel_i,
  input  logic [31:0]           word_i,
  input  logic [LINE_W-1:0]     line_i,
  output logic [LINE_W-1:0]     line_o,
  output logic [LINE_WORDS-1:0] mask_o,
  output logic                  valid_o,
  output logic [TAG_W-1:0]      tag_o
);
  logic [LINE_W-1:0]     line_q, line_d;
  logic [LINE_WORDS-1:0] mask_q, mask_d;
  logic                  valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  // A load only fills words not already written, so it serves both merge and plain fill
  for (genvar k = 0; k < LINE_WORDS; k++) begin : g_w
    assign line_d[32*k +: 32] = (wr_i && sel_i == 2'(k)) ? word_i :
                                (ld_i && !mask_q[k]) ? line_i[32*k +: 32] : line_q[32*k +: 32];
  end
  always_comb begin
    mask_d  = clr_i ? '0 : ld_i ? '1 : wr_i ? (mask_q | (LINE_WORDS'(1) << sel_i)) : mask_q;
    valid_d = clr_i ? 1'b0 : (wr_i || ld_i) ? 1'b1 : valid_q;
    tag_d   = (wr_i || ld_i) ? tag_i : tag_q;
  end
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      line_q  <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      tag_q   <= '0;
    end else begin
      line_q  <= line_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end
  assign line_o  = line_q;
  assign mask_o  = mask_q;
  assign valid_o = valid_q;
  assign tag_o   = tag_q;
endmodule

// File: rtl/ddr2_line_bridge.sv
// ddr2_line_bridge: 32-bit word requests to 128-bit DDR2 lines via a write-combine buffer and a read buffer.
module ddr2_line_bridge
  import ddr2_line_bridge_pkg::*;
#(
  parameter int ADDR_W     = 26,
  parameter int RD_TIMEOUT = 1023
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              flush_i,
  output logic [31:0]       rdata_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [31:0]       ddr_addr_o,
  output logic [127:0]      ddr_data_o,
  output logic              ddr_stb_o,
  input  logic              ddr_ack_i,
  input  logic [127:0]      ddr_rd_data_i,
  input  logic              ddr_rd_valid_i
);
  localparam int TAG_W = ADDR_W - 2;
  state_e                state_q;
  pend_e                 pend_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [31:0]           wdata_q, rdata_q;
  logic [9:0]            cnt_q;
  logic                  done_q, err_q, stb_q;
  logic [31:0]           ddr_addr_q;
  logic [LINE_W-1:0]     wb_line, rb_line;
  logic [LINE_WORDS-1:0] wb_mask, rb_mask, onehot;
  logic                  wb_v, rb_v;
  logic [TAG_W-1:0]      wb_tag, rb_tag, in_tag, wb_tag_in;
  logic [1:0]            in_sel;
  logic [31:0]           in_word;
  logic                  idle, wb_ok, wb_hit, rb_hit, full_after, wb_full, tmo;
  logic                  wb_wr, rb_wr, wb_ld, rb_ld, wb_clr, rb_clr;
  // In IDLE the live request is decoded; afterwards the latched one drives the buffers
  always_comb begin
    idle       = state_q == S_IDLE;
    in_tag     = idle ? addr_i[ADDR_W-1:2] : addr_q[ADDR_W-1:2];
    in_sel     = idle ? addr_i[1:0] : addr_q[1:0];
    in_word    = idle ? wdata_i : wdata_q;
    onehot     = LINE_WORDS'(1) << in_sel;
    wb_ok      = !wb_v || wb_tag == in_tag;
    wb_hit     = wb_v && wb_tag == in_tag && wb_mask[in_sel];
    rb_hit     = rb_v && rb_tag == in_tag && rb_mask[in_sel];
    full_after = (wb_mask | onehot) == '1;
    wb_full    = wb_mask == '1;
    tmo        = !ddr_rd_valid_i && cnt_q == 10'(RD_TIMEOUT - 1);
    wb_wr      = (idle && req_i && we_i && wb_ok) || (state_q == S_RESP && pend_q == P_WR);
    rb_wr      = wb_wr && rb_v && rb_tag == in_tag;
    wb_ld      = state_q == S_MRG_WAIT && ddr_rd_valid_i;
    rb_ld      = state_q == S_FILL_WAIT && ddr_rd_valid_i;
    wb_clr     = (state_q == S_WR_REQ && ddr_ack_i) || (state_q == S_MRG_WAIT && tmo);
    rb_clr     = state_q == S_FILL_RD;
    wb_tag_in  = wb_ld ? wb_tag : in_tag;
  end
  ddr2_line_buf #(.TAG_W(TAG_W)) u_wb (
    .clk_in(clk_in), .rst(rst), .clr_i(wb_clr), .wr_i(wb_wr), .ld_i(wb_ld), .tag_i(wb_tag_in),
    .sel_i(in_sel), .word_i(in_word), .line_i(ddr_rd_data_i),
    .line_o(wb_line), .mask_o(wb_mask), .valid_o(wb_v), .tag_o(wb_tag)
  );
  ddr2_line_buf #(.TAG_W(TAG_W)) u_rb (
    .clk_in(clk_in), .rst(rst), .clr_i(rb_clr), .wr_i(rb_wr), .ld_i(rb_ld), .tag_i(in_tag),
    .sel_i(in_sel), .word_i(in_word), .line_i(ddr_rd_data_i),
    .line_o(rb_line), .mask_o(rb_mask), .valid_o(rb_v), .tag_o(rb_tag)
  );
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pend_q     <= P_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      stb_q      <= 1'b0;
      ddr_addr_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            if (we_i && wb_ok) begin
              done_q <= 1'b1;
              if (full_after) begin
                state_q    <= S_WR_REQ;
                stb_q      <= 1'b1;
                ddr_addr_q <= 32'(in_tag);
                pend_q     <= P_NONE;
              end
            end else if (!we_i && (wb_hit || rb_hit)) begin
              done_q  <= 1'b1;
              rdata_q <= wb_hit ? word_of(wb_line, in_sel) : word_of(rb_line, in_sel);
            end else if (wb_v) begin
              pend_q     <= we_i ? P_WR : P_RD;
              state_q    <= wb_full ? S_WR_REQ : S_MRG_RD;
              stb_q      <= wb_full;
              ddr_addr_q <= 32'(wb_tag);
            end else begin
              pend_q     <= P_RD;
              state_q    <= S_FILL_RD;
              ddr_addr_q <= 32'(in_tag);
            end
          end else if (flush_i) begin
            if (wb_v) begin
              pend_q     <= P_FL;
              state_q    <= wb_full ? S_WR_REQ : S_MRG_RD;
              stb_q      <= wb_full;
              ddr_addr_q <= 32'(wb_tag);
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_MRG_RD, S_FILL_RD: begin
          state_q <= (state_q == S_MRG_RD) ? S_MRG_WAIT : S_FILL_WAIT;
          cnt_q   <= '0;
        end
        S_MRG_WAIT, S_FILL_WAIT: begin
          if (ddr_rd_valid_i) begin
            state_q <= (state_q == S_MRG_WAIT) ? S_WR_REQ : S_RESP;
            stb_q   <= state_q == S_MRG_WAIT;
          end else if (tmo) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            rdata_q <= TIMEOUT_DATA;
            pend_q  <= P_NONE;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
        S_WR_REQ: begin
          if (ddr_ack_i) begin
            stb_q <= 1'b0;
            if (pend_q == P_RD) begin
              state_q    <= S_FILL_RD;
              ddr_addr_q <= 32'(addr_q[ADDR_W-1:2]);
            end else begin
              state_q <= (pend_q == P_NONE) ? S_IDLE : S_RESP;
            end
          end
        end
        S_RESP: begin
          done_q  <= 1'b1;
          rdata_q <= (pend_q == P_RD) ? word_of(rb_line, in_sel) : rdata_q;
          pend_q  <= P_NONE;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign rdata_o    = rdata_q;
  assign done_o     = done_q;
  assign busy_o     = !idle;
  assign err_o      = err_q;
  assign ddr_addr_o = ddr_addr_q;
  assign ddr_data_o = wb_line;
  assign ddr_stb_o  = stb_q;
endmodule

// File: tb/tb_ddr2_line_bridge.sv
// tb_ddr2_line_bridge: directed steps with hand-computed expectations for ddr2_line_bridge.
module tb_ddr2_line_bridge;
  logic         clk_in = 1'b0, rst = 1'b1;
  logic         req_i = 1'b0, we_i = 1'b0, flush_i = 1'b0;
  logic [25:0]  addr_i = '0;
  logic [31:0]  wdata_i = '0;
  logic [31:0]  rdata_o, ddr_addr_o;
  logic         done_o, busy_o, err_o, ddr_stb_o;
  logic [127:0] ddr_data_o, rd_line = '0;
  logic         ddr_ack_i = 1'b0, ddr_rd_valid_i;
  logic         ack_en = 1'b1, rd_en = 1'b1;
  int           n_chk = 0, n_fail = 0, wr_cnt = 0, lat;
  logic [31:0]  last_addr = '0;
  logic [127:0] last_data = '0;

  always #5 clk_in = ~clk_in;
  assign ddr_rd_valid_i = rd_en && busy_o && !ddr_stb_o;

  ddr2_line_bridge dut (
    .clk_in(clk_in), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .flush_i(flush_i), .rdata_o(rdata_o), .done_o(done_o), .busy_o(busy_o), .err_o(err_o),
    .ddr_addr_o(ddr_addr_o), .ddr_data_o(ddr_data_o), .ddr_stb_o(ddr_stb_o), .ddr_ack_i(ddr_ack_i),
    .ddr_rd_data_i(rd_line), .ddr_rd_valid_i(ddr_rd_valid_i)
  );

  // DDR write side: acknowledge one cycle after stb is seen and record the accepted line
  initial forever begin
    @(posedge clk_in); #1;
    ddr_ack_i = ack_en && ddr_stb_o && !ddr_ack_i;
    if (ddr_ack_i) begin
      wr_cnt++;
      last_addr = ddr_addr_o;
      last_data = ddr_data_o;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic w, input logic fl, input logic [25:0] a, input logic [31:0] d, output int l);
    int n = 0;
    while (busy_o && n < 3000) begin @(posedge clk_in); #1; n++; end
    req_i = !fl; flush_i = fl; we_i = w; addr_i = a; wdata_i = d;
    @(posedge clk_in); #1;
    req_i = 1'b0; flush_i = 1'b0; l = 1;
    while (!done_o && l < 3000) begin @(posedge clk_in); #1; l++; end
  endtask

  task automatic settle();
    int n = 0;
    while (busy_o && n < 100) begin @(posedge clk_in); #1; n++; end
    chk("settle_busy", busy_o, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_done", done_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_stb", ddr_stb_o, 0);
    chk("rst_addr", ddr_addr_o, 0);
    chk("rst_data", ddr_data_o, 0);
    chk("rst_rdata", rdata_o, 0);
    rst = 1'b0;
    @(posedge clk_in); #1;
    // full line of writes goes out as one burst
    for (int i = 0; i < 4; i++) begin
      op(1'b1, 1'b0, 26'h10 + 26'(i), 32'(i + 1), lat);
      chk("wr_lat", lat, 1);
    end
    chk("full_stb", ddr_stb_o, 1);
    settle();
    chk("full_cnt", wr_cnt, 1);
    chk("full_addr", last_addr, 32'h4);
    chk("full_data", last_data, 128'h00000004_00000003_00000002_00000001);
    // partial line flushed by read-merge-write before another line is written
    op(1'b1, 1'b0, 26'h21, 32'hAA, lat);
    chk("p_lat", lat, 1);
    rd_line = {4{32'h55}};
    op(1'b1, 1'b0, 26'h40, 32'hBB, lat);
    chk("mrg_slow", lat > 2, 1);
    chk("mrg_cnt", wr_cnt, 2);
    chk("mrg_addr", last_addr, 32'h8);
    chk("mrg_data", last_data, 128'h00000055_00000055_000000AA_00000055);
    op(1'b0, 1'b0, 26'h40, 32'h0, lat);
    chk("wbhit_lat", lat, 1);
    chk("wbhit_data", rdata_o, 32'hBB);
    op(1'b0, 1'b1, 26'h0, 32'h0, lat);
    chk("fl_done", lat < 3000, 1);
    chk("fl_cnt", wr_cnt, 3);
    chk("fl_addr", last_addr, 32'h10);
    chk("fl_data", last_data, 128'h00000055_00000055_00000055_000000BB);
    op(1'b0, 1'b1, 26'h0, 32'h0, lat);
    chk("fl_empty_lat", lat, 1);
    chk("fl_empty_cnt", wr_cnt, 3);
    // read buffer fill and hits
    rd_line = 128'h00000004_00000003_00000002_00000001;
    op(1'b0, 1'b0, 26'h30, 32'h0, lat);
    chk("miss_slow", lat > 1, 1);
    chk("miss_data", rdata_o, 32'h1);
    op(1'b0, 1'b0, 26'h32, 32'h0, lat);
    chk("rbhit_lat", lat, 1);
    chk("rbhit_data", rdata_o, 32'h3);
    op(1'b0, 1'b0, 26'h30, 32'h0, lat);
    chk("rbhit2_lat", lat, 1);
    chk("rbhit2_data", rdata_o, 32'h1);
    op(1'b1, 1'b0, 26'h31, 32'h77, lat);
    chk("wr31_lat", lat, 1);
    op(1'b0, 1'b0, 26'h31, 32'h0, lat);
    chk("rd31_lat", lat, 1);
    chk("rd31_data", rdata_o, 32'h77);
    op(1'b0, 1'b1, 26'h0, 32'h0, lat);
    chk("fl2_addr", last_addr, 32'hC);
    chk("fl2_data", last_data, 128'h00000004_00000003_00000077_00000001);
    op(1'b0, 1'b0, 26'h31, 32'h0, lat);
    chk("coh_lat", lat, 1);
    chk("coh_data", rdata_o, 32'h77);
    // read timeout
    rd_en = 1'b0;
    op(1'b0, 1'b0, 26'h80, 32'h0, lat);
    chk("tmo_lat", lat >= 1023 && lat <= 1026, 1);
    chk("tmo_err", err_o, 1);
    chk("tmo_data", rdata_o, 32'hDEADBEEF);
    rd_en = 1'b1;
    op(1'b1, 1'b0, 26'h90, 32'h1, lat);
    chk("err_sticky", err_o, 1);
    op(1'b0, 1'b1, 26'h0, 32'h0, lat);
    // reset while a write request is waiting for ack
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 26'h100 + 26'(i), 32'hF0 + 32'(i), lat);
    chk("pre_rst_stb", ddr_stb_o, 1);
    chk("pre_rst_busy", busy_o, 1);
    repeat (3) @(posedge clk_in);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_stb", ddr_stb_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_err", err_o, 0);
    @(negedge clk_in) rst = 1'b0;
    ack_en = 1'b1;
    @(posedge clk_in); #1;
    rd_line = 128'h0000000D_0000000C_0000000B_0000000A;
    op(1'b0, 1'b0, 26'h102, 32'h0, lat);
    chk("post_rst_miss", lat > 1, 1);
    chk("post_rst_data", rdata_o, 32'hC);
    chk("post_rst_cnt", wr_cnt, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
